// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: synchronises completed SPI frames, decodes and executes
// register commands, builds the response word and arbitrates local inc/dec on reg 0.
module spi_cmd_ctrl #(
  parameter int NREG    = 4,
  parameter int DATA_W  = 16,
  parameter int STEP    = 100,
  parameter int MAX_VAL = 2000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              frame_in,
  input  logic                     frame_rdy,
  output logic [31:0]              resp_word,
  input  logic                     local_inc,
  input  logic                     local_dec,
  output logic [NREG*DATA_W-1:0]   regs_flat,
  output logic                     cmd_strobe
);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_DECODE, S_EXEC, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              rdy_s1_q, rdy_s2_q, rdy_s3_q;
  logic              frame_edge;
  logic              fpend_q, fpend_d, drop;
  logic [3:0]        op_q, addr_q;
  logic [DATA_W-1:0] data_q;
  logic              bad_op_q, bad_addr_q, bad_op_d, bad_addr_d;
  logic [3:0]        seq_q, seq_d;
  logic [7:0]        err_q, err_d;
  logic [31:0]       resp_q, resp_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              lpend_q, lpend_d, lpend_up_q, lpend_up_d;
  logic              capture_en, decode_en, exec_en;
  logic              wr_en, wr_r0, loc_req;
  logic [15:0]       rdata;
  logic [1:0]        err_add;
  logic [8:0]        err_sum;
  logic              unused_rsvd;

  assign unused_rsvd = ^frame_in[23:16];

  // Saturating local step on reg 0; values already above the ceiling are left alone.
  function automatic logic [DATA_W-1:0] step_val(input logic [DATA_W-1:0] v, input logic up);
    if (up) begin
      if (32'(v) >= 32'(MAX_VAL))         return v;
      if (32'(v) + 32'(STEP) > 32'(MAX_VAL)) return DATA_W'(MAX_VAL);
      return v + DATA_W'(STEP);
    end
    if (32'(v) < 32'(STEP)) return '0;
    return v - DATA_W'(STEP);
  endfunction

  // 2-FF synchroniser plus an edge-detect flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_s1_q <= 1'b0;
      rdy_s2_q <= 1'b0;
      rdy_s3_q <= 1'b0;
    end else begin
      rdy_s1_q <= frame_rdy;
      rdy_s2_q <= rdy_s1_q;
      rdy_s3_q <= rdy_s2_q;
    end
  end

  assign frame_edge = rdy_s2_q & ~rdy_s3_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (frame_edge || fpend_q) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_DECODE;
      S_DECODE:  state_d = S_EXEC;
      S_EXEC:    state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    capture_en = (state_q == S_CAPTURE);
    decode_en  = (state_q == S_DECODE);
    exec_en    = (state_q == S_EXEC);
    cmd_strobe = (state_q == S_RESP);
  end

  // In IDLE a held edge and a fresh edge can coincide: one is consumed, the other stays held.
  always_comb begin
    fpend_d = fpend_q;
    drop    = 1'b0;
    if (state_q == S_IDLE) begin
      fpend_d = fpend_q & frame_edge;
    end else if (frame_edge) begin
      if (fpend_q) drop    = 1'b1;
      else         fpend_d = 1'b1;
    end
  end

  always_comb begin
    bad_op_d   = (op_q > 4'h3);
    bad_addr_d = ((op_q == 4'h1) || (op_q == 4'h2)) && ({28'h0, addr_q} >= 32'(NREG));
    wr_en      = exec_en && (op_q == 4'h1) && !bad_addr_q;
    wr_r0      = wr_en && (addr_q == 4'h0);
    rdata      = '0;
    if (op_q == 4'h2 && !bad_addr_q) begin
      for (int unsigned i = 0; i < NREG; i++)
        if (addr_q == 4'(i)) rdata = 16'(regs_q[i]);
    end else if (op_q == 4'h3) begin
      rdata = 16'(NREG);
    end
  end

  always_comb begin
    err_add = 2'(exec_en && (bad_op_q || bad_addr_q)) + 2'(drop);
    err_sum = {1'b0, err_q} + {7'h0, err_add};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    seq_d   = exec_en ? seq_q + 4'd1 : seq_q;
    resp_d  = exec_en ? {4'hA, seq_d, err_d[3:0], 2'b00, bad_addr_q, bad_op_q, rdata} : resp_q;
  end

  // An SPI write to reg 0 wins over a simultaneous local op, which is parked for one cycle.
  always_comb begin
    loc_req    = local_inc ^ local_dec;
    lpend_d    = lpend_q;
    lpend_up_d = lpend_up_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && addr_q == 4'(i)) regs_d[i] = data_q;
    end
    if (wr_r0) begin
      if (loc_req && !lpend_q) begin
        lpend_d    = 1'b1;
        lpend_up_d = local_inc;
      end
    end else if (lpend_q) begin
      regs_d[0] = step_val(regs_d[0], lpend_up_q);
      lpend_d   = 1'b0;
    end else if (loc_req) begin
      regs_d[0] = step_val(regs_d[0], local_inc);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpend_q    <= 1'b0;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      bad_op_q   <= 1'b0;
      bad_addr_q <= 1'b0;
      seq_q      <= '0;
      err_q      <= '0;
      resp_q     <= '0;
      lpend_q    <= 1'b0;
      lpend_up_q <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      fpend_q    <= fpend_d;
      seq_q      <= seq_d;
      err_q      <= err_d;
      resp_q     <= resp_d;
      lpend_q    <= lpend_d;
      lpend_up_q <= lpend_up_d;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      if (capture_en) begin
        op_q   <= frame_in[31:28];
        addr_q <= frame_in[27:24];
        data_q <= frame_in[DATA_W-1:0];
      end
      if (decode_en) begin
        bad_op_q   <= bad_op_d;
        bad_addr_q <= bad_addr_d;
      end
    end
  end

  assign resp_word = resp_q;

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NREG; i++) regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
  end

endmodule
